// File: rtl/bus_server.sv
// Windowed register responder: captures a request, waits WAIT_STATES cycles, commits and pulses ack.
// ack lands WAIT_STATES+1 cycles after capture; the client is stalled in RELEASE until it drops rq.
module bus_server #(
   parameter int DATA_WIDTH           = 8,
   parameter int ADDR_WIDTH           = 4,
   parameter int ADDR_SPACE_BEGINNING = 0,
   parameter int ADDR_SPACE_END       = 3,
   parameter int WAIT_STATES          = 2,
   parameter int CNT_WIDTH            = 16
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [ADDR_WIDTH-1:0] address,
   input  logic                  rq,
   input  logic                  wr_ni,
   input  logic [DATA_WIDTH-1:0] dataW,
   output logic                  ack,
   output logic [DATA_WIDTH-1:0] dataR,
   output logic                  err,
   output logic [CNT_WIDTH-1:0]  rd_count,
   output logic [CNT_WIDTH-1:0]  wr_count
);

   localparam int DEPTH = ADDR_SPACE_END - ADDR_SPACE_BEGINNING + 1;
   localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int WCW   = (WAIT_STATES > 1) ? $clog2(WAIT_STATES) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_RELEASE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic                  wr_ni_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic [WCW-1:0]        wait_cnt;
   logic [DATA_WIDTH-1:0] mem [DEPTH];

   logic [ADDR_WIDTH-1:0] c_addr;
   logic                  c_rd;
   logic [DATA_WIDTH-1:0] c_data;
   logic                  in_win;
   logic [IDXW-1:0]       idx;
   logic                  commit;

   // With no wait states the commit edge is the capture edge, so operands come straight from the inputs.
   always_comb begin
      c_addr = addr_q;
      c_rd   = wr_ni_q;
      c_data = data_q;
      if (state == S_IDLE) begin
         c_addr = address;
         c_rd   = wr_ni;
         c_data = dataW;
      end
      in_win = (int'(c_addr) >= ADDR_SPACE_BEGINNING) && (int'(c_addr) <= ADDR_SPACE_END);
      idx    = IDXW'(int'(c_addr) - ADDR_SPACE_BEGINNING);
      commit = ((state == S_IDLE) && rq && (WAIT_STATES == 0)) ||
               ((state == S_WAIT) && (wait_cnt == '0));
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         ack      <= 1'b0;
         err      <= 1'b0;
         dataR    <= '0;
         rd_count <= '0;
         wr_count <= '0;
         addr_q   <= '0;
         wr_ni_q  <= 1'b0;
         data_q   <= '0;
         wait_cnt <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         ack <= 1'b0;
         err <= 1'b0;
         if (commit) begin
            ack <= 1'b1;
            err <= !in_win;
            if (in_win) begin
               if (c_rd) begin
                  dataR <= mem[idx];
                  if (rd_count != '1) rd_count <= rd_count + 1'b1;
               end else begin
                  mem[idx] <= c_data;
                  if (wr_count != '1) wr_count <= wr_count + 1'b1;
               end
            end else if (c_rd) begin
               dataR <= '0;
            end
         end
         case (state)
            S_IDLE: begin
               if (rq) begin
                  addr_q  <= address;
                  wr_ni_q <= wr_ni;
                  data_q  <= dataW;
                  if (WAIT_STATES == 0) begin
                     state <= S_ACK;
                  end else begin
                     wait_cnt <= WCW'(WAIT_STATES - 1);
                     state    <= S_WAIT;
                  end
               end
            end
            S_WAIT: begin
               if (wait_cnt == '0) state <= S_ACK;
               else wait_cnt <= wait_cnt - 1'b1;
            end
            S_ACK:     state <= S_RELEASE;
            S_RELEASE: if (!rq) state <= S_IDLE;
            default:   state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_server.sv
// Two responders share one stimulus stream: A (window 0..3, 2 wait states, 16-bit counters)
// and B (window 1..3, no wait states, 2-bit counters), each scored against an address-level model.
module tb_bus_server;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] address = '0;
   logic       rq = 1'b0;
   logic       wr_ni = 1'b1;
   logic [7:0] dataW = '0;

   logic        ack_a, err_a, ack_b, err_b;
   logic [7:0]  dataR_a, dataR_b;
   logic [15:0] rd_a, wr_a;
   logic [1:0]  rd_b, wr_b;

   int checks = 0;
   int errors = 0;

   int beg_p[2]  = '{0, 1};
   int end_p[2]  = '{3, 3};
   int ws_p[2]   = '{2, 0};
   int cmax_p[2] = '{65535, 3};

   // reference model, indexed by absolute bus address
   int mm[2][16];
   int rdc[2], wrc[2], drm[2], exp_err[2];

   // observations captured in the ack cycle
   int          ack_cnt[2], ack_k[2];
   logic [31:0] err_o[2], dr_o[2], rd_o[2], wr_o[2];

   always #5 clk = ~clk;

   bus_server #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ADDR_SPACE_BEGINNING(0), .ADDR_SPACE_END(3),
                .WAIT_STATES(2), .CNT_WIDTH(16)) dut_a (
      .clk(clk), .reset(reset), .address(address), .rq(rq), .wr_ni(wr_ni), .dataW(dataW),
      .ack(ack_a), .dataR(dataR_a), .err(err_a), .rd_count(rd_a), .wr_count(wr_a));

   bus_server #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ADDR_SPACE_BEGINNING(1), .ADDR_SPACE_END(3),
                .WAIT_STATES(0), .CNT_WIDTH(2)) dut_b (
      .clk(clk), .reset(reset), .address(address), .rq(rq), .wr_ni(wr_ni), .dataW(dataW),
      .ack(ack_b), .dataR(dataR_b), .err(err_b), .rd_count(rd_b), .wr_count(wr_b));

   function automatic void model_reset();
      for (int d = 0; d < 2; d++) begin
         for (int a = 0; a < 16; a++) mm[d][a] = 0;
         rdc[d] = 0; wrc[d] = 0; drm[d] = 0; exp_err[d] = 0;
      end
   endfunction

   function automatic void model_txn(input int a, input bit rd, input int dat);
      for (int d = 0; d < 2; d++) begin
         if (a >= beg_p[d] && a <= end_p[d]) begin
            exp_err[d] = 0;
            if (rd) begin
               drm[d] = mm[d][a];
               if (rdc[d] < cmax_p[d]) rdc[d]++;
            end else begin
               mm[d][a] = dat & 255;
               if (wrc[d] < cmax_p[d]) wrc[d]++;
            end
         end else begin
            exp_err[d] = 1;
            if (rd) drm[d] = 0;
         end
      end
   endfunction

   task automatic sample_acks(input int k);
      if (ack_a === 1'b1) begin
         ack_cnt[0]++; ack_k[0] = k;
         err_o[0] = 32'(err_a); dr_o[0] = 32'(dataR_a); rd_o[0] = 32'(rd_a); wr_o[0] = 32'(wr_a);
      end
      if (ack_b === 1'b1) begin
         ack_cnt[1]++; ack_k[1] = k;
         err_o[1] = 32'(err_b); dr_o[1] = 32'(dataR_b); rd_o[1] = 32'(rd_b); wr_o[1] = 32'(wr_b);
      end
   endtask

   // Raises rq, scrambles inputs after capture, holds rq for 'hold' extra cycles, then drops it.
   task automatic do_txn(input int a, input bit rd, input int dat, input int hold);
      @(negedge clk);
      address = 4'(a); wr_ni = rd; dataW = 8'(dat); rq = 1'b1;
      model_txn(a, rd, dat);
      ack_cnt = '{0, 0}; ack_k = '{-1, -1};
      for (int k = 0; k < 4 + hold; k++) begin
         @(posedge clk); @(negedge clk);
         sample_acks(k);
         address = 4'($urandom_range(0, 15)); wr_ni = 1'($urandom); dataW = 8'($urandom);
      end
      rq = 1'b0;
      @(posedge clk); @(negedge clk);
      sample_acks(99);
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if ({ack_a, err_a, dataR_a, rd_a, wr_a} !== '0) begin
         errors++;
         $display("FAIL reset_a: ack=%b err=%b dataR=%h rd=%0d wr=%0d, required all 0", ack_a, err_a, dataR_a, rd_a, wr_a);
      end
      checks++;
      if ({ack_b, err_b, dataR_b, rd_b, wr_b} !== '0) begin
         errors++;
         $display("FAIL reset_b: ack=%b err=%b dataR=%h rd=%0d wr=%0d, required all 0", ack_b, err_b, dataR_b, rd_b, wr_b);
      end
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_write();
      do_txn(2, 1'b0, 8'hA5, 0);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ack_cnt[d] !== 1 || ack_k[d] !== ws_p[d]) begin
            errors++;
            $display("FAIL write_ack[%0d]: pulses=%0d at=%0d, required 1 at %0d", d, ack_cnt[d], ack_k[d], ws_p[d]);
         end
         checks++;
         if (err_o[d] !== 0 || wr_o[d] !== 1 || dr_o[d] !== 0) begin
            errors++;
            $display("FAIL write_state[%0d]: err=%0d wr=%0d dataR=%h, required 0 1 00", d, err_o[d], wr_o[d], dr_o[d]);
         end
      end
   endtask

   task automatic test_read();
      do_txn(2, 1'b1, 0, 0);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ack_cnt[d] !== 1 || ack_k[d] !== ws_p[d]) begin
            errors++;
            $display("FAIL read_ack[%0d]: pulses=%0d at=%0d, required 1 at %0d", d, ack_cnt[d], ack_k[d], ws_p[d]);
         end
         checks++;
         if (dr_o[d] !== 32'hA5 || rd_o[d] !== 1 || err_o[d] !== 0) begin
            errors++;
            $display("FAIL read_data[%0d]: dataR=%h rd=%0d err=%0d, required a5 1 0", d, dr_o[d], rd_o[d], err_o[d]);
         end
      end
      checks++;
      if (dataR_a !== 8'hA5 || dataR_b !== 8'hA5) begin
         errors++;
         $display("FAIL read_hold: dataR a=%h b=%h after rq drop, required a5", dataR_a, dataR_b);
      end
   endtask

   task automatic test_out_of_window();
      do_txn(9, 1'b1, 0, 0);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ack_cnt[d] !== 1 || err_o[d] !== 1 || dr_o[d] !== 0 || rd_o[d] !== 1 || wr_o[d] !== 1) begin
            errors++;
            $display("FAIL oow_read[%0d]: pulses=%0d err=%0d dataR=%h rd=%0d wr=%0d, required 1 1 00 1 1",
                     d, ack_cnt[d], err_o[d], dr_o[d], rd_o[d], wr_o[d]);
         end
      end
      do_txn(9, 1'b0, $urandom_range(0, 255), 0);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ack_cnt[d] !== 1 || err_o[d] !== 1 || wr_o[d] !== 1 || dr_o[d] !== 0) begin
            errors++;
            $display("FAIL oow_write[%0d]: pulses=%0d err=%0d wr=%0d dataR=%h, required 1 1 1 00",
                     d, ack_cnt[d], err_o[d], wr_o[d], dr_o[d]);
         end
      end
      for (int a = 0; a < 4; a++) begin
         do_txn(a, 1'b1, 0, 0);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (dr_o[d] !== 32'(drm[d]) || err_o[d] !== 32'(exp_err[d])) begin
               errors++;
               $display("FAIL mem_scan[%0d] addr %0d: dataR=%h err=%0d, required %h %0d",
                        d, a, dr_o[d], err_o[d], drm[d], exp_err[d]);
            end
         end
      end
   endtask

   task automatic test_hold_rq();
      do_txn(3, 1'b0, 8'h5A, 10);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ack_cnt[d] !== 1 || ack_k[d] !== ws_p[d]) begin
            errors++;
            $display("FAIL hold_single_ack[%0d]: pulses=%0d at=%0d, required 1 at %0d", d, ack_cnt[d], ack_k[d], ws_p[d]);
         end
      end
      do_txn(3, 1'b1, 0, 0);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (ack_cnt[d] !== 1 || dr_o[d] !== 32'h5A) begin
            errors++;
            $display("FAIL hold_next[%0d]: pulses=%0d dataR=%h, required 1 5a", d, ack_cnt[d], dr_o[d]);
         end
      end
   endtask

   task automatic test_reset_mid_txn();
      int seen_a;
      @(negedge clk);
      address = 4'd1; wr_ni = 1'b0; dataW = 8'h3C; rq = 1'b1;
      @(posedge clk); @(negedge clk);
      checks++;
      if (ack_b !== 1'b1 || ack_a !== 1'b0) begin
         errors++;
         $display("FAIL rst_mid_e0: ack_a=%b ack_b=%b after capture edge, required 0 1", ack_a, ack_b);
      end
      @(posedge clk); @(negedge clk);
      reset = 1'b1; rq = 1'b0;
      seen_a = 0;
      for (int k = 0; k < 5; k++) begin
         if (k == 2) reset = 1'b0;
         @(posedge clk); @(negedge clk);
         if (ack_a !== 1'b0) seen_a++;
      end
      model_reset();
      checks++;
      if (seen_a !== 0) begin
         errors++;
         $display("FAIL rst_mid_noack: A acked %0d times after reset, required 0", seen_a);
      end
      do_txn(1, 1'b1, 0, 0);
      for (int d = 0; d < 2; d++) begin
         checks++;
         if (dr_o[d] !== 0 || rd_o[d] !== 1 || wr_o[d] !== 0) begin
            errors++;
            $display("FAIL rst_mid_mem[%0d]: dataR=%h rd=%0d wr=%0d, required 00 1 0", d, dr_o[d], rd_o[d], wr_o[d]);
         end
      end
   endtask

   task automatic test_saturation();
      for (int n = 0; n < 5; n++) begin
         do_txn($urandom_range(1, 3), 1'b0, $urandom_range(0, 255), 0);
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (wr_o[d] !== 32'(wrc[d])) begin
               errors++;
               $display("FAIL sat_step[%0d] write %0d: wr=%0d, required %0d", d, n, wr_o[d], wrc[d]);
            end
         end
      end
      checks++;
      if (wr_b !== 2'd3 || wr_a !== 16'd5) begin
         errors++;
         $display("FAIL sat_final: wr_b=%0d wr_a=%0d, required 3 5", wr_b, wr_a);
      end
   endtask

   task automatic test_random();
      for (int n = 0; n < 30; n++) begin
         int a;
         a = ($urandom_range(0, 3) == 0) ? $urandom_range(4, 15) : $urandom_range(0, 3);
         do_txn(a, 1'($urandom), $urandom_range(0, 255), $urandom_range(0, 2));
         for (int d = 0; d < 2; d++) begin
            checks++;
            if (ack_cnt[d] !== 1 || ack_k[d] !== ws_p[d] || err_o[d] !== 32'(exp_err[d]) ||
                dr_o[d] !== 32'(drm[d]) || rd_o[d] !== 32'(rdc[d]) || wr_o[d] !== 32'(wrc[d])) begin
               errors++;
               $display("FAIL random[%0d] txn %0d addr %0d: pulses=%0d at=%0d err=%0d dataR=%h rd=%0d wr=%0d, required 1 %0d %0d %h %0d %0d",
                        d, n, a, ack_cnt[d], ack_k[d], err_o[d], dr_o[d], rd_o[d], wr_o[d],
                        ws_p[d], exp_err[d], drm[d], rdc[d], wrc[d]);
            end
         end
      end
   endtask

   initial begin
      model_reset();
      test_reset();
      test_write();
      test_read();
      test_out_of_window();
      test_hold_rq();
      test_reset_mid_txn();
      test_saturation();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete within time limit");
      $fatal(1);
   end

endmodule

// File: doc/bus_server.md
# bus_server

Responder end of the bus-arbiter request/acknowledge protocol. It sits behind the arbiter, receives the granted client's `address`, `rq`, `wr_ni` and `dataW`, and serves reads and writes from an internal register array mapped to a configurable address window. Each accepted request completes with a one-cycle `ack` after a programmable number of wait states. Saturating read and write access counters are provided for bench and debug observation.

## Interface
- `DATA_WIDTH`, 8, data bus width
- `ADDR_WIDTH`, 4, address bus width
- `ADDR_SPACE_BEGINNING`, 0, lowest served address (inclusive)
- `ADDR_SPACE_END`, 3, highest served address (inclusive); must be ≥ `ADDR_SPACE_BEGINNING`
- `WAIT_STATES`, 2, extra cycles between request capture and `ack` (0 allowed)
- `CNT_WIDTH`, 16, width of the access counters

- `clk` input 1 — single clock, rising edge
- `reset` input 1 — asynchronous, active-high reset
- `address` input ADDR_WIDTH — request address
- `rq` input 1 — request from the granted client
- `wr_ni` input 1 — 1 = read, 0 = write
- `dataW` input DATA_WIDTH — write data
- `ack` output 1 — one-cycle completion strobe
- `dataR` output DATA_WIDTH — read data, registered
- `err` output 1 — high with `ack` when the address is outside the window
- `rd_count` output CNT_WIDTH — completed in-window reads, saturating
- `wr_count` output CNT_WIDTH — completed in-window writes, saturating

## Operation
- Storage: DEPTH = `ADDR_SPACE_END - ADDR_SPACE_BEGINNING + 1` words of `DATA_WIDTH`. Index = `address - ADDR_SPACE_BEGINNING`. All words clear to 0 on reset.
- FSM states:
  - IDLE: when `rq`=1 at an edge, latch `address`, `wr_ni` and `dataW`. If `WAIT_STATES`=0, go to ACK; otherwise load the wait counter with `WAIT_STATES-1` and go to WAIT.
  - WAIT: at each edge, if the counter is 0, go to ACK; otherwise decrement. Input changes are ignored; the latched values are used.
  - ACK: `ack`=1 for exactly this cycle, then go to RELEASE.
  - RELEASE: stay until `rq`=0 is sampled, then go to IDLE. A new request is never accepted in the same edge that leaves RELEASE.
- Transaction commit happens on the edge that enters ACK.
  - In-window write: `mem[index] <= latched dataW`; `wr_count` increments.
  - In-window read: `dataR <= mem[index]`; `rd_count` increments.
  - Out-of-window (`address < ADDR_SPACE_BEGINNING` or `address > ADDR_SPACE_END`): no memory change and no counter change. A read loads `dataR` with 0. A write leaves `dataR` unchanged. `err`=1 during ACK.
- `dataR` holds its value between reads.
- Counters saturate at all-ones and do not wrap.
- `err` is 0 in every state except ACK.

## Timing
- Reset values: state IDLE, `ack`=0, `err`=0, `dataR`=0, `rd_count`=0, `wr_count`=0, memory all 0.
- Let E0 be the edge where IDLE samples `rq`=1. `ack` and `err` are high in the cycle following edge E0+`WAIT_STATES`.
  - `WAIT_STATES`=0: `ack` is high in the cycle right after E0.
  - `WAIT_STATES`=2: `ack` is high between E2 and E3.
- `dataR` is valid in the same cycle `ack` is high.
- `ack` and `err` are decoded from the state register only. There is no combinational path from inputs to outputs.
- Minimum spacing between captures is `WAIT_STATES`+3 edges. With `rq` held high after `ack`, the server stays in RELEASE and issues no further `ack`.
- `reset` asserted mid-transaction (WAIT or ACK) returns the block to IDLE immediately. No write commits unless the ACK-entry edge already occurred. Memory and counters clear.
- `wr_ni` or `address` changing during WAIT has no effect on the transaction in flight.

## Test plan
- Reset, then write 0xA5 to address 2 (`wr_ni`=0, `WAIT_STATES`=2). Expect `ack` high exactly one cycle, at E0+2; `err`=0; `wr_count`=1; `dataR`=0.
- Read address 2. Expect `ack` at E0+2 with `dataR`=0xA5; `rd_count`=1; `dataR` still 0xA5 after `rq` drops.
- Read address 9 (out of window). Expect `ack`=1 and `err`=1 in the same cycle, `dataR`=0, counters unchanged. Then write address 9 and check that all memory words are unchanged.
- Hold `rq`=1 for 10 cycles after one request. Expect a single `ack` pulse, state held in RELEASE, and the next `ack` only after `rq` goes 0 and then 1 again.
- Assert `reset` one cycle before ACK during a write of 0x3C to address 1. Expect `ack` never asserted and address 1 reading 0 afterwards. Repeat with `WAIT_STATES`=0 and expect `ack` the cycle after E0.
- Force `wr_count` to saturation with CNT_WIDTH=2 (four writes, then one more). Expect `wr_count`=3 held, not wrapped to 0.
